// File: rtl/rf_trace_pkg.sv
// rf_trace_pkg: shared state encoding, halt default and trace-entry layout
package rf_trace_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
  localparam logic [31:0] HALT_INSN_DEF = 32'h00100073;
  typedef struct packed {
    logic        ovf;
    logic [15:0] ts;
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;
  function automatic int entry_w(int xlen, int aw, int ts_w);
    return 1 + ts_w + aw + xlen;
  endfunction
endpackage

// File: rtl/rf_write_tracer_if.sv
// rf_write_tracer_if: valid/ready trace stream from the tracer to its consumer
interface rf_write_tracer_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int TS_W = 16
);
  logic            valid;
  logic            ready;
  logic [AW-1:0]   addr;
  logic [XLEN-1:0] data;
  logic [TS_W-1:0] ts;
  logic            ovf;
  modport master(output valid, addr, data, ts, ovf, input ready);
  modport slave(input valid, addr, data, ts, ovf, output ready);
endinterface

// File: rtl/trace_fifo.sv
// trace_fifo: first-word-fall-through FIFO with full-with-pop passthrough and sync flush
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty   = level == '0;
  assign full    = level == (PW+1)'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];
  // pointers and occupancy; a full FIFO may accept a push when it pops in the same cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      wp    <= wp + PW'(do_push);
      rp    <= rp + PW'(do_pop);
      level <= level + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
  // storage has no reset; the head is only meaningful while not empty
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp] <= din;
  end
endmodule

// File: rtl/rf_write_tracer.sv
// rf_write_tracer: timestamps register-file writes and streams them out, draining on halt
module rf_write_tracer
  import rf_trace_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          NREG      = 32,
  parameter int          DEPTH     = 16,
  parameter int          TS_W      = 16,
  parameter int          DROP_W    = 16,
  parameter logic [31:0] HALT_INSN = HALT_INSN_DEF
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic                        clear,
  input  logic                        filter_x0,
  input  logic                        halt_en,
  input  logic                        wr_en,
  input  logic [$clog2(NREG)-1:0]     wr_addr,
  input  logic [XLEN-1:0]             wr_data,
  input  logic [31:0]                 instr,
  rf_write_tracer_if.master           trace,
  output logic [$clog2(DEPTH):0]      level,
  output logic [DROP_W-1:0]           drop_count,
  output logic [1:0]                  state,
  output logic                        done
);
  localparam int AW = $clog2(NREG);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int EW = entry_w(XLEN, AW, TS_W);
  state_t st, nx;
  logic [TS_W-1:0] ts;
  logic pending_ovf, capture, done_set;
  logic qw, halt, full, empty, pop_ok, accepted, dropped;
  logic [EW-1:0] din, dout;
  assign qw       = wr_en && capture && !(filter_x0 && wr_addr == '0);
  assign halt     = halt_en && instr == HALT_INSN && st == RUN;
  assign pop_ok   = trace.ready && !empty;
  assign accepted = qw && (!full || pop_ok);
  assign dropped  = qw && !accepted;
  assign din      = {pending_ovf, ts, wr_addr, wr_data};
  assign trace.valid = !empty;
  assign {trace.ovf, trace.ts, trace.addr, trace.data} = dout;
  assign state = st;
  trace_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .flush (clear),
    .push  (qw && !clear),
    .pop   (trace.ready && !clear),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );
  // state register and the registered one-cycle done pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st   <= IDLE;
      done <= 1'b0;
    end else begin
      st   <= nx;
      done <= !clear && done_set;
    end
  end
  // next state; clear wins over everything, halt wins over enable dropping
  always_comb begin
    nx = st;
    if (clear) nx = enable ? RUN : IDLE;
    else if (st == IDLE) nx = enable ? RUN : IDLE;
    else if (st == RUN) nx = halt ? DRAIN : (enable ? RUN : IDLE);
    else if (st == DRAIN) nx = (empty || (level == LW'(1) && pop_ok)) ? DONE : DRAIN;
  end
  // outputs decoded from the FSM
  always_comb begin
    capture  = st == RUN;
    done_set = st == DRAIN && nx == DONE;
  end
  // timestamp, saturating drop counter and the overflow flag carried into the next stored entry
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ts          <= '0;
      drop_count  <= '0;
      pending_ovf <= 1'b0;
    end else if (clear) begin
      ts          <= '0;
      drop_count  <= '0;
      pending_ovf <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      if (dropped && drop_count != '1) drop_count <= drop_count + 1'b1;
      if (dropped) pending_ovf <= 1'b1;
      else if (accepted) pending_ovf <= 1'b0;
    end
  end
endmodule
